// File: rtl/frv_masked_pkg.sv
// Shared op encodings and per-op share handling for the masked bitwise pipeline.
package frv_masked_pkg;

    typedef enum logic [2:0] {
        FRV_MBW_XOR  = 3'b000,
        FRV_MBW_AND  = 3'b001,
        FRV_MBW_IOR  = 3'b010,
        FRV_MBW_NOT  = 3'b011,
        FRV_MBW_ANDN = 3'b100
    } mbwOp_e;

    // IOR is built from AND by De Morgan on the a1/b1 shares; ANDN complements b1 only.
    // Returned as {invertA1, invertB1}.
    function automatic logic [1:0] shareInvert(input logic [2:0] op);
        logic [1:0] inv;
        inv = 2'b00;
        case (op)
            FRV_MBW_IOR:  inv = 2'b11;
            FRV_MBW_ANDN: inv = 2'b01;
            default:      inv = 2'b00;
        endcase
        return inv;
    endfunction

endpackage

// File: rtl/frv_masked_and_pipe.sv
// DOM-style masked AND: the cross-domain terms t1/t3 are registered so the two
// share domains only meet through flops.
module frv_masked_and_pipe #(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [N-1:0] b0Next_i,
    input  logic [N-1:0] b1Next_i,
    input  logic [N-1:0] z0Next_i,
    input  logic [N-1:0] a0_i,
    input  logic [N-1:0] a1_i,
    input  logic [N-1:0] b0_i,
    input  logic [N-1:0] b1_i,
    input  logic [N-1:0] z0_i,
    input  logic [N-1:0] z1_i,
    output logic [N-1:0] r0_o,
    output logic [N-1:0] r1_o
);

    logic [N-1:0] t1_q;
    logic [N-1:0] t3_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            t1_q <= '0;
            t3_q <= '0;
        end else if (en_i) begin
            t1_q <= b1Next_i ^ z0Next_i;
            t3_q <= b0Next_i ^ z0Next_i;
        end
    end

    assign r0_o = ((t1_q ^ b0_i) & a0_i) ^ (a0_i & z0_i) ^ z1_i;
    assign r1_o = ((t3_q ^ b1_i) & a1_i) ^ (a1_i & z0_i) ^ z1_i;

endmodule

// File: rtl/frv_masked_bitwise_pipe.sv
// Two-stage masked bitwise unit (XOR/AND/IOR/NOT/ANDN) on Boolean shares with
// valid/ready handshaking, flush and optional zeroisation of emptied stages.
module frv_masked_bitwise_pipe
    import frv_masked_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit ZEROISE = 1'b1
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a0,
    input  logic [XLEN-1:0] i_a1,
    input  logic [XLEN-1:0] i_b0,
    input  logic [XLEN-1:0] i_b1,
    input  logic [XLEN-1:0] i_z0,
    input  logic [XLEN-1:0] i_z1,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [XLEN-1:0] o_r0,
    output logic [XLEN-1:0] o_r1
);

    logic            s1Valid_q, s1Valid_d;
    logic [2:0]      s1Op_q;
    logic [XLEN-1:0] s1A0_q, s1A1_q, s1B0_q, s1B1_q, s1Z0_q, s1Z1_q;
    logic            s2Valid_q, s2Valid_d;
    logic [XLEN-1:0] s2R0_q, s2R1_q;
    logic [XLEN-1:0] r0_d, r1_d;

    logic            s2Adv, accept, s1Clr, s2Clr;
    logic [1:0]      inv;
    logic [XLEN-1:0] a1In, b1In;
    logic [XLEN-1:0] andR0, andR1;

    assign inv  = shareInvert(i_op);
    assign a1In = inv[1] ? ~i_a1 : i_a1;
    assign b1In = inv[0] ? ~i_b1 : i_b1;

    assign s2Adv   = !s2Valid_q || o_ready;
    assign i_ready = (!s1Valid_q || s2Adv) && !i_flush;
    assign accept  = i_valid && i_ready;

    // A stage is wiped on reset, and with ZEROISE on flush or whenever it empties.
    assign s1Clr = g_reset || (ZEROISE && (i_flush || (s2Adv && !accept)));
    assign s2Clr = g_reset || (ZEROISE && (i_flush || (s2Adv && !s1Valid_q)));

    always_comb begin
        s1Valid_d = s1Valid_q;
        if (g_reset || i_flush) begin
            s1Valid_d = 1'b0;
        end else if (accept) begin
            s1Valid_d = 1'b1;
        end else if (s2Adv) begin
            s1Valid_d = 1'b0;
        end

        s2Valid_d = s2Valid_q;
        if (g_reset || i_flush) begin
            s2Valid_d = 1'b0;
        end else if (s2Adv) begin
            s2Valid_d = s1Valid_q;
        end
    end

    frv_masked_and_pipe #(
        .N(XLEN)
    ) u_and (
        .clk_i    (g_clk),
        .clr_i    (s1Clr),
        .en_i     (accept),
        .b0Next_i (i_b0),
        .b1Next_i (b1In),
        .z0Next_i (i_z0),
        .a0_i     (s1A0_q),
        .a1_i     (s1A1_q),
        .b0_i     (s1B0_q),
        .b1_i     (s1B1_q),
        .z0_i     (s1Z0_q),
        .z1_i     (s1Z1_q),
        .r0_o     (andR0),
        .r1_o     (andR1)
    );

    // Reserved encodings fall through to a masked zero (both shares = z1).
    always_comb begin
        r0_d = s1Z1_q;
        r1_d = s1Z1_q;
        case (s1Op_q)
            FRV_MBW_XOR: begin
                r0_d = s1A0_q ^ s1B0_q ^ s1Z1_q;
                r1_d = s1A1_q ^ s1B1_q ^ s1Z1_q;
            end
            FRV_MBW_AND, FRV_MBW_ANDN: begin
                r0_d = andR0;
                r1_d = andR1;
            end
            FRV_MBW_IOR: begin
                r0_d = andR0;
                r1_d = ~andR1;
            end
            FRV_MBW_NOT: begin
                r0_d = s1A0_q ^ s1Z1_q;
                r1_d = ~s1A1_q ^ s1Z1_q;
            end
            default: begin
                r0_d = s1Z1_q;
                r1_d = s1Z1_q;
            end
        endcase
    end

    always_ff @(posedge g_clk) begin
        s1Valid_q <= s1Valid_d;
        if (s1Clr) begin
            s1Op_q <= '0;
            s1A0_q <= '0;
            s1A1_q <= '0;
            s1B0_q <= '0;
            s1B1_q <= '0;
            s1Z0_q <= '0;
            s1Z1_q <= '0;
        end else if (accept) begin
            s1Op_q <= i_op;
            s1A0_q <= i_a0;
            s1A1_q <= a1In;
            s1B0_q <= i_b0;
            s1B1_q <= b1In;
            s1Z0_q <= i_z0;
            s1Z1_q <= i_z1;
        end
    end

    always_ff @(posedge g_clk) begin
        s2Valid_q <= s2Valid_d;
        if (s2Clr) begin
            s2R0_q <= '0;
            s2R1_q <= '0;
        end else if (s2Adv && s1Valid_q) begin
            s2R0_q <= r0_d;
            s2R1_q <= r1_d;
        end
    end

    assign o_valid = s2Valid_q;
    assign o_r0    = s2R0_q;
    assign o_r1    = s2R1_q;

endmodule
